seg_scan_capture: RTL

Receive-side counterpart of the multiplexed seven-segment driver. It watches a time-multiplexed digit-enable/segment bus (`an`, `sseg`) and demultiplexes it back into four stable per-digit segment registers. It decodes each register to a hex nibble plus a decimal-point flag and pulses a strobe once per complete scan frame. It sits on the display bus as a loop-back checker or display sniffer, in the same clock domain as the driver.

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg7_to_hex.sv | 40 ++++
 rtl/seg_scan_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package : seg_pkg
// Brief   : Segment bit positions, hex glyph table and capture FSM states.
// Rev     : 1.0
// ============================================================================
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
// Module : seg7_to_hex
// Brief  : Combinational seven-segment pattern to hex nibble decoder.
// Rev    : 1.0
// ============================================================================
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       ok_o
);

    always_comb begin
        nib_o = 4'h0;
        ok_o  = 1'b1;
        case (seg_i)
            GLYPH_0: nib_o = 4'h0;
            GLYPH_1: nib_o = 4'h1;
            GLYPH_2: nib_o = 4'h2;
            GLYPH_3: nib_o = 4'h3;
            GLYPH_4: nib_o = 4'h4;
            GLYPH_5: nib_o = 4'h5;
            GLYPH_6: nib_o = 4'h6;
            GLYPH_7: nib_o = 4'h7;
            GLYPH_8: nib_o = 4'h8;
            GLYPH_9: nib_o = 4'h9;
            GLYPH_A: nib_o = 4'hA;
            GLYPH_B: nib_o = 4'hB;
            GLYPH_C: nib_o = 4'hC;
            GLYPH_D: nib_o = 4'hD;
            GLYPH_E: nib_o = 4'hE;
            GLYPH_F: nib_o = 4'hF;
            default: ok_o  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module : seg_scan_capture
// Brief  : Demultiplexes a scanned an/sseg display bus into four digit registers.
// Rev    : 1.0
// ============================================================================
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [7:0]  out0,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic [15:0] hex,
    output logic [3:0]  hex_ok,
    output logic [3:0]  dp,
    output logic        frame_strobe,
    output logic        stale,
    output logic        an_err
);

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    logic [3:0]           an_q;
    logic [7:0]           sseg_q;
    logic [11:0]          prev_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic [7:0]           shadow_q [4];
    logic [7:0]           out_q [4];
    logic [3:0]           seen_q, seen_d;
    state_t               state_q, state_d;
    logic                 strobe_q;
    logic                 an_err_q;

    logic w_onehot;
    logic w_same;
    logic w_capture;
    logic w_idle_full;
    logic w_multi_raw;

    assign w_onehot    = (an_q != 4'd0) && ((an_q & (an_q - 4'd1)) == 4'd0);
    assign w_same      = ({an_q, sseg_q} == prev_q);
    // Fires only on the transition into STABLE, so a long dwell captures once.
    assign w_capture   = w_onehot && w_same && (cnt_q == c_STABLE - 8'd1);
    assign w_idle_full = &idle_q;
    assign w_multi_raw = ((an & (an - 4'd1)) != 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (!w_same || !w_onehot)
            cnt_d = 8'd1;
        else if (cnt_q != c_STABLE)
            cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        idle_d = idle_q;
        if (w_capture)
            idle_d = '0;
        else if (!w_idle_full)
            idle_d = idle_q + TIMEOUT_W'(1);
    end

    always_comb begin
        seen_d  = seen_q;
        state_d = state_q;
        if (state_q == PUBLISH) begin
            seen_d  = 4'd0;
            state_d = COLLECT;
        end
        if (w_idle_full) begin
            seen_d  = 4'd0;
            state_d = COLLECT;
        end
        // Capture is applied after the clears so it always keeps its seen bit.
        if (w_capture) begin
            seen_d = seen_d | an_q;
            if (state_q == COLLECT && seen_d == 4'hF)
                state_d = PUBLISH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q     <= 4'd0;
            sseg_q   <= 8'd0;
            prev_q   <= 12'd0;
            cnt_q    <= 8'd0;
            idle_q   <= '0;
            seen_q   <= 4'd0;
            state_q  <= COLLECT;
            strobe_q <= 1'b0;
            an_err_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k] <= 8'd0;
                out_q[k]    <= 8'd0;
            end
        end else begin
            an_q     <= an;
            sseg_q   <= sseg;
            prev_q   <= {an_q, sseg_q};
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            seen_q   <= seen_d;
            state_q  <= state_d;
            strobe_q <= (state_q == PUBLISH);
            an_err_q <= w_multi_raw;
            for (int k = 0; k < 4; k++) begin
                if (w_capture && an_q[k])
                    shadow_q[k] <= sseg_q;
                if (state_q == PUBLISH)
                    out_q[k] <= shadow_q[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_dec
            seg7_to_hex u_dec (
                .seg_i (out_q[k][SEG_G:SEG_A]),
                .nib_o (hex[4*k+3:4*k]),
                .ok_o  (hex_ok[k])
            );
            assign dp[k] = out_q[k][SEG_DP];
        end
    endgenerate

    assign out0         = out_q[0];
    assign out1         = out_q[1];
    assign out2         = out_q[2];
    assign out3         = out_q[3];
    assign frame_strobe = strobe_q;
    assign stale        = w_idle_full;
    assign an_err       = an_err_q;

endmodule
`default_nettype wire
